// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC waveform generator.
//   state_e   : generator FSM states
//   WAVE_*    : wave_sel encodings
//   midscale(): offset-binary zero code for a given sample width
package dac_pkg;

    typedef enum logic [1:0] {
        StWaitLock,
        StSettle,
        StIdle,
        StRun
    } state_e;

    localparam logic [1:0] WAVE_SAW = 2'd0;
    localparam logic [1:0] WAVE_TRI = 2'd1;
    localparam logic [1:0] WAVE_SQ  = 2'd2;
    localparam logic [1:0] WAVE_DC  = 2'd3;

    // Offset-binary zero: only the MSB of the sample word set.
    function automatic logic [31:0] midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/dac_wave_gen_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input level
//   q     : synchronised level, two clk cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dac_wave_gen.sv
// DDS waveform source for the DAC path.
// Waits for a stable PLL lock, then runs a phase accumulator and maps its top
// bits to saw / triangle / square / DC offset-binary samples. Output is forced
// to midscale with dac_valid low whenever the generator is not running.
//   clk        : 125 MHz PLL output clock
//   rst_n      : asynchronous active-low reset
//   pll_locked : PLL lock flag, asynchronous to clk
//   enable     : run request
//   wave_sel   : 0 saw, 1 triangle, 2 square, 3 DC midscale
//   tw_in      : tuning word, f_out = tw * f_clk / 2^PHASE_W
//   tw_load    : one-cycle strobe capturing tw_in into the shadow register
//   dac_data   : registered sample to the DAC
//   dac_valid  : dac_data is a generated sample
//   running    : FSM is in RUN
module dac_wave_gen
    import dac_pkg::*;
#(
    parameter int unsigned DAC_W     = 14,
    parameter int unsigned PHASE_W   = 32,
    parameter int unsigned LOCK_WAIT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               enable,
    input  logic [1:0]         wave_sel,
    input  logic [PHASE_W-1:0] tw_in,
    input  logic               tw_load,
    output logic [DAC_W-1:0]   dac_data,
    output logic               dac_valid,
    output logic               running
);

    localparam logic [DAC_W-1:0] MIDSCALE = DAC_W'(midscale(DAC_W));
    localparam int unsigned      CNT_W    = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

    logic lock_s;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] shadow_tw_q, shadow_tw_d;
    logic [PHASE_W-1:0] active_tw_q, active_tw_d;
    logic [DAC_W-1:0]   dac_data_d;
    logic               dac_valid_d;

    logic [PHASE_W:0]   sum;
    logic               run_stay;
    logic               run_start;
    logic [DAC_W:0]     p;
    logic [DAC_W-1:0]   sample;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Next-state and settle counter; loss of lock overrides every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!lock_s) begin
            state_d = StWaitLock;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StWaitLock: begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end
                StSettle: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (enable) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!enable) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StWaitLock;
            endcase
        end
    end

    // Phase accumulator and tuning registers.
    always_comb begin
        run_stay    = (state_q == StRun) && (state_d == StRun);
        run_start   = (state_q == StIdle) && (state_d == StRun);
        sum         = {1'b0, phase_q} + {1'b0, active_tw_q};
        phase_d     = run_stay ? sum[PHASE_W-1:0] : '0;
        shadow_tw_d = tw_load ? tw_in : shadow_tw_q;
        active_tw_d = active_tw_q;
        // Swap tuning words only on the accumulator carry so the output
        // frequency changes at a phase-continuous point.
        if (run_start || (run_stay && sum[PHASE_W])) begin
            active_tw_d = shadow_tw_q;
        end
    end

    // Sample mapping from the top DAC_W+1 phase bits.
    always_comb begin
        p = phase_q[PHASE_W-1 -: DAC_W+1];
        case (wave_sel)
            WAVE_SAW: sample = p[DAC_W:1];
            WAVE_TRI: sample = p[DAC_W] ? ~p[DAC_W-1:0] : p[DAC_W-1:0];
            WAVE_SQ:  sample = {DAC_W{p[DAC_W]}};
            default:  sample = MIDSCALE;
        endcase
        dac_data_d  = (state_q == StRun) ? sample : MIDSCALE;
        dac_valid_d = (state_q == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWaitLock;
            cnt_q       <= '0;
            phase_q     <= '0;
            shadow_tw_q <= '0;
            active_tw_q <= '0;
            dac_data    <= MIDSCALE;
            dac_valid   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            shadow_tw_q <= shadow_tw_d;
            active_tw_q <= active_tw_d;
            dac_data    <= dac_data_d;
            dac_valid   <= dac_valid_d;
        end
    end

    assign running = (state_q == StRun);

endmodule
